booth_mult_arbiter: RTL and testbench

- Round-robin scheduler that shares one booth_multiplier among N requesters.
- Accepts operand pairs from requesters over a req/ack handshake and launches the multiplier with a one-cycle start pulse.
- Waits the multiplier's fixed latency, then captures the signed product and returns it with a per-requester done pulse.
- Sits between the requesting datapath blocks and a single booth_multiplier instance, which is external and driven through the mul_* ports.

---
 rtl/booth_arb_pkg.sv | 15 +
 rtl/rr_pick.sv | 28 ++
 rtl/booth_mult_arbiter.sv | 100 ++++++++++
 tb/tb_booth_mult_arbiter.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/booth_arb_pkg.sv
// Shared types and default sizing for the booth multiplier arbiter.
package booth_arb_pkg;

  localparam int N_DEF       = 4;
  localparam int W_DEF       = 8;
  localparam int LATENCY_DEF = 8;

  typedef enum logic [1:0] {
    IDLE,
    LAUNCH,
    WAIT,
    DONE
  } state_t;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set req bit after last, wrapping.
module rr_pick #(
  parameter int N   = 4,
  parameter int IDW = $clog2(N)
) (
  input  logic [N-1:0]   req,
  input  logic [IDW-1:0] last,
  output logic [IDW-1:0] win,
  output logic           vld
);

  int idx;

  // Scan from the farthest offset down so the nearest set bit is assigned last.
  always_comb begin
    win = '0;
    vld = 1'b0;
    idx = 0;
    for (int k = N; k >= 1; k--) begin
      idx = (int'(last) + k) % N;
      if (req[idx]) begin
        win = IDW'(idx);
        vld = 1'b1;
      end
    end
  end

endmodule

// File: rtl/booth_mult_arbiter.sv
// Shares one external booth multiplier among N requesters, round-robin,
// one operation in flight at a time.
module booth_mult_arbiter
  import booth_arb_pkg::*;
#(
  parameter int N       = N_DEF,
  parameter int W       = W_DEF,
  parameter int LATENCY = LATENCY_DEF,
  parameter int IDW     = $clog2(N)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N-1:0]            req,
  input  logic [N*W-1:0]          a_bus,
  input  logic [N*W-1:0]          b_bus,
  output logic [N-1:0]            ack,
  output logic [N-1:0]            done,
  output logic signed [2*W-1:0]   result,
  output logic [IDW-1:0]          owner,
  output logic                    busy,
  output logic signed [W-1:0]     mul_a,
  output logic signed [W-1:0]     mul_b,
  output logic                    mul_start,
  input  logic signed [2*W-1:0]   mul_ab
);

  localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [N-1:0] ONE = N'(1);

  state_t         state;
  logic [CW-1:0]  cnt;
  logic [IDW-1:0] last_owner;
  logic [IDW-1:0] pick_id;
  logic           pick_vld;

  rr_pick #(
    .N   (N),
    .IDW (IDW)
  ) u_pick (
    .req  (req),
    .last (last_owner),
    .win  (pick_id),
    .vld  (pick_vld)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      ack        <= '0;
      done       <= '0;
      result     <= '0;
      owner      <= '0;
      busy       <= 1'b0;
      mul_a      <= '0;
      mul_b      <= '0;
      mul_start  <= 1'b0;
      cnt        <= '0;
      last_owner <= IDW'(N - 1);
    end else begin
      case (state)
        IDLE: begin
          done <= '0;
          if (pick_vld) begin
            mul_a      <= $signed(a_bus[pick_id*W +: W]);
            mul_b      <= $signed(b_bus[pick_id*W +: W]);
            owner      <= pick_id;
            last_owner <= pick_id;
            ack        <= ONE << pick_id;
            mul_start  <= 1'b1;
            busy       <= 1'b1;
            state      <= LAUNCH;
          end
        end
        LAUNCH: begin
          ack       <= '0;
          mul_start <= 1'b0;
          cnt       <= CW'(LATENCY - 1);
          state     <= WAIT;
        end
        // Operands stay parked on mul_a/mul_b until the product is taken.
        WAIT: begin
          if (cnt == '0) begin
            result <= mul_ab;
            done   <= ONE << owner;
            state  <= DONE;
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        DONE: begin
          done  <= '0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_booth_mult_arbiter.sv
// Scoreboard bench for booth_mult_arbiter with a behavioural multiplier model.
module tb_booth_mult_arbiter;

  localparam int N   = 4;
  localparam int W   = 8;
  localparam int L   = 8;
  localparam int IDW = 2;
  localparam logic [N-1:0] ONE = N'(1);

  logic                  clk = 1'b0;
  logic                  rst;
  logic [N-1:0]          req;
  logic [N*W-1:0]        a_bus;
  logic [N*W-1:0]        b_bus;
  logic [N-1:0]          ack;
  logic [N-1:0]          done;
  logic signed [2*W-1:0] result;
  logic [IDW-1:0]        owner;
  logic                  busy;
  logic signed [W-1:0]   mul_a;
  logic signed [W-1:0]   mul_b;
  logic                  mul_start;
  logic signed [2*W-1:0] mul_ab;

  always #5 clk = ~clk;

  booth_mult_arbiter #(.N(N), .W(W), .LATENCY(L), .IDW(IDW)) u_dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .a_bus     (a_bus),
    .b_bus     (b_bus),
    .ack       (ack),
    .done      (done),
    .result    (result),
    .owner     (owner),
    .busy      (busy),
    .mul_a     (mul_a),
    .mul_b     (mul_b),
    .mul_start (mul_start),
    .mul_ab    (mul_ab)
  );

  // Multiplier model: product valid for exactly one cycle, LATENCY edges after start is sampled.
  logic signed [2*W-1:0] pipe_p [L];
  logic                  pv [L];
  always @(posedge clk) begin
    pipe_p[0] <= mul_a * mul_b;
    pv[0]     <= mul_start;
    for (int i = 1; i < L; i++) begin
      pipe_p[i] <= pipe_p[i-1];
      pv[i]     <= pv[i-1];
    end
  end
  assign mul_ab = (pv[L-1] === 1'b1) ? pipe_p[L-1] : 16'sh5A5A;

  typedef struct {
    int                    id;
    logic signed [W-1:0]   a;
    logic signed [W-1:0]   b;
    logic signed [2*W-1:0] p;
  } op_t;

  typedef struct {
    logic [N-1:0]        ack;
    logic signed [W-1:0] a;
    logic signed [W-1:0] b;
    logic                st;
    logic [IDW-1:0]      own;
    int                  cyc;
  } ack_ev_t;

  typedef struct {
    logic [N-1:0]          done;
    logic [N-1:0]          ack;
    logic signed [2*W-1:0] res;
    logic [IDW-1:0]        own;
    int                    cyc;
  } done_ev_t;

  op_t      sb[$];
  ack_ev_t  ack_q[$];
  done_ev_t done_q[$];

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int st_cycles = 0;
  int busy_cycles = 0;
  logic [N-1:0] hold;

  // Advance to the next falling edge, log DUT events, and let acked requesters drop req.
  task automatic tick();
    @(negedge clk);
    cyc++;
    if (mul_start === 1'b1) st_cycles++;
    if (busy === 1'b1) busy_cycles++;
    if (ack !== '0) ack_q.push_back('{ack, mul_a, mul_b, mul_start, owner, cyc});
    if (done !== '0) done_q.push_back('{done, ack, result, owner, cyc});
    if (ack !== '0) req = req & ~(ack & ~hold);
  endtask

  task automatic run(input int n);
    repeat (n) tick();
  endtask

  task automatic wait_acks(input int n, input int budget);
    int b;
    b = 0;
    while (ack_q.size() < n && b < budget) begin
      tick();
      b++;
    end
  endtask

  task automatic clear();
    sb.delete();
    ack_q.delete();
    done_q.delete();
    st_cycles   = 0;
    busy_cycles = 0;
  endtask

  task automatic do_reset();
    req  = '0;
    hold = '0;
    rst  = 1'b1;
    run(2);
    rst  = 1'b0;
  endtask

  task automatic set_ops(input int id, input logic signed [W-1:0] a, input logic signed [W-1:0] b);
    a_bus[id*W +: W] = a;
    b_bus[id*W +: W] = b;
  endtask

  task automatic test_reset();
    rst = 1'b1; req = '0; hold = '0; a_bus = '0; b_bus = '0;
    run(3);
    tests++; if (ack !== '0)        begin fails++; $display("FAIL reset_ack: got %b want 0", ack); end
    tests++; if (done !== '0)       begin fails++; $display("FAIL reset_done: got %b want 0", done); end
    tests++; if (result !== '0)     begin fails++; $display("FAIL reset_result: got %0d want 0", result); end
    tests++; if (owner !== '0)      begin fails++; $display("FAIL reset_owner: got %0d want 0", owner); end
    tests++; if (busy !== 1'b0)     begin fails++; $display("FAIL reset_busy: got %b want 0", busy); end
    tests++; if (mul_start !== 1'b0) begin fails++; $display("FAIL reset_start: got %b want 0", mul_start); end
    tests++; if (mul_a !== '0 || mul_b !== '0) begin fails++; $display("FAIL reset_mul_ops: got %0d,%0d want 0,0", mul_a, mul_b); end
    rst = 1'b0;
    run(1);
  endtask

  task automatic test_single();
    done_event_t_placeholder: begin end
    clear();
    sb.push_back('{0, 8'sd3, 8'sd17, 16'sd51});
    set_ops(0, 8'sd3, 8'sd17);
    req[0] = 1'b1;
    wait_acks(1, 20);
    run(L + 4);
    tests++; if (ack_q.size() != 1) begin fails++; $display("FAIL single_ack_count: got %0d want 1", ack_q.size()); end
    if (ack_q.size() >= 1) begin
      tests++; if (ack_q[0].ack !== 4'b0001) begin fails++; $display("FAIL single_ack: got %b want 0001", ack_q[0].ack); end
      tests++; if (ack_q[0].st !== 1'b1) begin fails++; $display("FAIL single_start_with_ack: got %b want 1", ack_q[0].st); end
      tests++; if (ack_q[0].a !== 8'sd3 || ack_q[0].b !== 8'sd17) begin fails++; $display("FAIL single_mul_ops: got %0d,%0d want 3,17", ack_q[0].a, ack_q[0].b); end
    end
    tests++; if (st_cycles != 1) begin fails++; $display("FAIL single_start_len: got %0d want 1", st_cycles); end
    tests++; if (busy_cycles != L + 2) begin fails++; $display("FAIL single_busy_len: got %0d want %0d", busy_cycles, L + 2); end
    tests++; if (done_q.size() != 1) begin fails++; $display("FAIL single_done_count: got %0d want 1", done_q.size()); end
    if (done_q.size() >= 1 && ack_q.size() >= 1) begin
      tests++; if (done_q[0].cyc - ack_q[0].cyc != L + 1) begin fails++; $display("FAIL single_latency: got %0d want %0d", done_q[0].cyc - ack_q[0].cyc, L + 1); end
      tests++; if (done_q[0].own !== 2'd0) begin fails++; $display("FAIL single_owner: got %0d want 0", done_q[0].own); end
    end
    while (done_q.size() > 0 && sb.size() > 0) begin
      done_ev_t d; op_t e;
      d = done_q.pop_front(); e = sb.pop_front();
      tests++; if (d.done !== (ONE << e.id) || d.res !== e.p) begin fails++; $display("FAIL single_result: got done=%b res=%0d want done=%b res=%0d", d.done, d.res, ONE << e.id, e.p); end
    end
    tests++; if (result !== 16'sd51) begin fails++; $display("FAIL single_result_held: got %0d want 51", result); end
  endtask

  task automatic test_all_four();
    do_reset();
    clear();
    sb.push_back('{0, 8'sd7,    8'sd7,    16'sd49});
    sb.push_back('{1, -8'sd3,   8'sd5,    -16'sd15});
    sb.push_back('{2, -8'sd8,   -8'sd8,   16'sd64});
    sb.push_back('{3, 8'sd127,  -8'sd128, -16'sd16256});
    foreach (sb[i]) set_ops(sb[i].id, sb[i].a, sb[i].b);
    req = 4'b1111;
    wait_acks(4, 80);
    run(L + 4);
    tests++; if (ack_q.size() != 4) begin fails++; $display("FAIL all4_ack_count: got %0d want 4", ack_q.size()); end
    for (int i = 0; i < ack_q.size() && i < sb.size(); i++) begin
      tests++; if (ack_q[i].ack !== (ONE << sb[i].id) || ack_q[i].a !== sb[i].a || ack_q[i].b !== sb[i].b)
        begin fails++; $display("FAIL all4_grant%0d: got ack=%b ops=%0d,%0d want ack=%b ops=%0d,%0d", i, ack_q[i].ack, ack_q[i].a, ack_q[i].b, ONE << sb[i].id, sb[i].a, sb[i].b); end
      if (i > 0) begin
        tests++; if (ack_q[i].cyc - ack_q[i-1].cyc != L + 3) begin fails++; $display("FAIL all4_spacing%0d: got %0d want %0d", i, ack_q[i].cyc - ack_q[i-1].cyc, L + 3); end
      end
    end
    tests++; if (done_q.size() != 4) begin fails++; $display("FAIL all4_done_count: got %0d want 4", done_q.size()); end
    while (done_q.size() > 0 && sb.size() > 0) begin
      done_ev_t d; op_t e;
      d = done_q.pop_front(); e = sb.pop_front();
      tests++; if (d.done !== (ONE << e.id) || d.res !== e.p || d.ack !== '0) begin fails++; $display("FAIL all4_result: got done=%b ack=%b res=%0d want done=%b ack=0 res=%0d", d.done, d.ack, d.res, ONE << e.id, e.p); end
    end
  endtask

  task automatic test_fairness();
    clear();
    sb.push_back('{0, 8'sd5,  8'sd6, 16'sd30});
    sb.push_back('{2, -8'sd7, 8'sd9, -16'sd63});
    sb.push_back('{0, 8'sd5,  8'sd6, 16'sd30});
    sb.push_back('{2, -8'sd7, 8'sd9, -16'sd63});
    set_ops(0, 8'sd5, 8'sd6);
    set_ops(2, -8'sd7, 8'sd9);
    hold = 4'b0101;
    req  = 4'b0101;
    wait_acks(4, 80);
    hold = '0;
    req  = '0;
    run(L + 4);
    tests++; if (ack_q.size() != 4) begin fails++; $display("FAIL fair_ack_count: got %0d want 4", ack_q.size()); end
    for (int i = 0; i < ack_q.size() && i < sb.size(); i++) begin
      tests++; if (ack_q[i].ack !== (ONE << sb[i].id)) begin fails++; $display("FAIL fair_grant%0d: got %b want %b", i, ack_q[i].ack, ONE << sb[i].id); end
    end
    while (done_q.size() > 0 && sb.size() > 0) begin
      done_ev_t d; op_t e;
      d = done_q.pop_front(); e = sb.pop_front();
      tests++; if (d.done !== (ONE << e.id) || d.res !== e.p) begin fails++; $display("FAIL fair_result: got done=%b res=%0d want done=%b res=%0d", d.done, d.res, ONE << e.id, e.p); end
    end
    tests++; if (sb.size() != 0 || done_q.size() != 0) begin fails++; $display("FAIL fair_leftover: got sb=%0d done=%0d want 0,0", sb.size(), done_q.size()); end
  endtask

  task automatic test_reset_midop();
    clear();
    set_ops(2, 8'sd9, 8'sd9);
    req[2] = 1'b1;
    wait_acks(1, 20);
    run(4);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL midrst_busy: got %b want 0", busy); end
    tests++; if (mul_start !== 1'b0) begin fails++; $display("FAIL midrst_start: got %b want 0", mul_start); end
    tests++; if (owner !== '0 || result !== '0) begin fails++; $display("FAIL midrst_regs: got owner=%0d result=%0d want 0,0", owner, result); end
    run(L + 6);
    tests++; if (done_q.size() != 0) begin fails++; $display("FAIL midrst_no_done: got %0d done pulses want 0", done_q.size()); end
    clear();
    sb.push_back('{1, -8'sd1, -8'sd1, 16'sd1});
    set_ops(1, -8'sd1, -8'sd1);
    req[1] = 1'b1;
    wait_acks(1, 20);
    run(L + 4);
    tests++; if (ack_q.size() != 1 || ack_q[0].ack !== 4'b0010) begin fails++; $display("FAIL midrst_next_ack: got count=%0d want one ack to 0010", ack_q.size()); end
    tests++; if (done_q.size() != 1) begin fails++; $display("FAIL midrst_next_done: got %0d want 1", done_q.size()); end
    while (done_q.size() > 0 && sb.size() > 0) begin
      done_ev_t d; op_t e;
      d = done_q.pop_front(); e = sb.pop_front();
      tests++; if (d.done !== (ONE << e.id) || d.res !== e.p) begin fails++; $display("FAIL midrst_result: got done=%b res=%0d want done=%b res=%0d", d.done, d.res, ONE << e.id, e.p); end
    end
  endtask

  task automatic test_pulse_while_busy();
    clear();
    sb.push_back('{0, -8'sd128, -8'sd128, 16'sd16384});
    set_ops(0, -8'sd128, -8'sd128);
    set_ops(3, 8'sd2, 8'sd2);
    req[0] = 1'b1;
    wait_acks(1, 20);
    run(3);
    req[3] = 1'b1;
    tick();
    req[3] = 1'b0;
    run(L + 6);
    tests++; if (ack_q.size() != 1) begin fails++; $display("FAIL pulse_ack_count: got %0d want 1", ack_q.size()); end
    if (ack_q.size() >= 1) begin
      tests++; if (ack_q[0].ack !== 4'b0001) begin fails++; $display("FAIL pulse_ack: got %b want 0001", ack_q[0].ack); end
    end
    while (done_q.size() > 0 && sb.size() > 0) begin
      done_ev_t d; op_t e;
      d = done_q.pop_front(); e = sb.pop_front();
      tests++; if (d.done !== (ONE << e.id) || d.res !== e.p) begin fails++; $display("FAIL pulse_result: got done=%b res=%0d want done=%b res=%0d", d.done, d.res, ONE << e.id, e.p); end
    end
    tests++; if (sb.size() != 0 || done_q.size() != 0) begin fails++; $display("FAIL pulse_leftover: got sb=%0d done=%0d want 0,0", sb.size(), done_q.size()); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_single();
    test_all_four();
    test_fairness();
    test_reset_midop();
    test_pulse_while_busy();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
